// File: rtl/bram_4096x4_dp.sv
// True dual-port 4096x4 synchronous RAM with per-bit write masks and registered,
// read-first outputs. Both ports share one clock; port 1 wins bits that both ports write.
module bram_4096x4_dp #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CE0,
  input  logic [ADDR_WIDTH-1:0] A0,
  input  logic [DATA_WIDTH-1:0] D0,
  input  logic                  WE0,
  input  logic [DATA_WIDTH-1:0] WEM0,
  output logic [DATA_WIDTH-1:0] Q0,
  input  logic                  CE1,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [DATA_WIDTH-1:0] D1,
  input  logic                  WE1,
  input  logic [DATA_WIDTH-1:0] WEM1,
  output logic [DATA_WIDTH-1:0] Q1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] q0_q;
  logic [DATA_WIDTH-1:0] q0_d;
  logic [DATA_WIDTH-1:0] q1_q;
  logic [DATA_WIDTH-1:0] q1_d;
  logic                  wr0_s;
  logic                  wr1_s;

  // Read data is taken from the array before this edge's writes land (read-first).
  always_comb begin
    q0_d  = q0_q;
    q1_d  = q1_q;
    wr0_s = RSTN & CE0 & WE0;
    wr1_s = RSTN & CE1 & WE1;
    if (CE0) begin
      q0_d = mem_q[A0];
    end else begin
      q0_d = q0_q;
    end
    if (CE1) begin
      q1_d = mem_q[A1];
    end else begin
      q1_d = q1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      q0_q <= '0;
      q1_q <= '0;
    end else begin
      q0_q <= q0_d;
      q1_q <= q1_d;
    end
  end

  // Port 1's assignments come last so it takes any bit both ports write.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (wr0_s && WEM0[i]) begin
        mem_q[A0][i] <= D0[i];
      end
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (wr1_s && WEM1[i]) begin
        mem_q[A1][i] <= D1[i];
      end
    end
  end

  assign Q0 = q0_q;
  assign Q1 = q1_q;

endmodule

// File: tb/tb_bram_4096x4_dp.sv
// Self-checking bench for bram_4096x4_dp: directed scenarios plus randomized traffic
// compared against an array-based reference memory that tracks which bits are defined.
module tb_bram_4096x4_dp;

  logic        CLK;
  logic        RSTN;
  logic        CE0;
  logic [11:0] A0;
  logic [3:0]  D0;
  logic        WE0;
  logic [3:0]  WEM0;
  logic [3:0]  Q0;
  logic        CE1;
  logic [11:0] A1;
  logic [3:0]  D1;
  logic        WE1;
  logic [3:0]  WEM1;
  logic [3:0]  Q1;

  logic [3:0] ref_mem   [4096];
  logic [3:0] ref_known [4096];
  logic [3:0] exp_q0;
  logic [3:0] exp_k0;
  logic [3:0] exp_q1;
  logic [3:0] exp_k1;
  int         n_checks;
  int         n_errors;

  bram_4096x4_dp #(.ADDR_WIDTH(12), .DATA_WIDTH(4)) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .CE0 (CE0),
    .A0  (A0),
    .D0  (D0),
    .WE0 (WE0),
    .WEM0(WEM0),
    .Q0  (Q0),
    .CE1 (CE1),
    .A1  (A1),
    .D1  (D1),
    .WE1 (WE1),
    .WEM1(WEM1),
    .Q1  (Q1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict outputs from the reference memory, then compare
  // only the bits whose stored value is defined.
  task automatic do_cycle(input string tag, input logic rst_n,
                          input logic ce0, input logic we0, input logic [11:0] a0,
                          input logic [3:0] d0, input logic [3:0] m0,
                          input logic ce1, input logic we1, input logic [11:0] a1,
                          input logic [3:0] d1, input logic [3:0] m1);
    RSTN = rst_n;
    CE0 = ce0; WE0 = we0; A0 = a0; D0 = d0; WEM0 = m0;
    CE1 = ce1; WE1 = we1; A1 = a1; D1 = d1; WEM1 = m1;
    if (!rst_n) begin
      exp_q0 = 4'h0; exp_k0 = 4'hF;
      exp_q1 = 4'h0; exp_k1 = 4'hF;
    end else begin
      if (ce0) begin
        exp_q0 = ref_mem[a0]; exp_k0 = ref_known[a0];
      end
      if (ce1) begin
        exp_q1 = ref_mem[a1]; exp_k1 = ref_known[a1];
      end
      if (ce0 && we0) begin
        ref_mem[a0]   = (ref_mem[a0] & ~m0) | (d0 & m0);
        ref_known[a0] = ref_known[a0] | m0;
      end
      if (ce1 && we1) begin
        ref_mem[a1]   = (ref_mem[a1] & ~m1) | (d1 & m1);
        ref_known[a1] = ref_known[a1] | m1;
      end
    end
    @(posedge CLK);
    #1;
    check_eq({tag, "/q0"}, Q0 & exp_k0, exp_q0 & exp_k0);
    check_eq({tag, "/q1"}, Q1 & exp_k1, exp_q1 & exp_k1);
  endtask

  initial begin
    logic        r_rst;
    logic        r_ce0;
    logic        r_we0;
    logic        r_ce1;
    logic        r_we1;
    logic [11:0] r_a0;
    logic [11:0] r_a1;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4096; i++) ref_known[i] = 4'h0;
    exp_q0 = 4'h0; exp_k0 = 4'h0; exp_q1 = 4'h0; exp_k1 = 4'h0;

    do_cycle("init_rst", 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("init_rst", 1'b0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("pre5",     1'b1, 1'b1, 1'b1, 12'h005, 4'hA, 4'hF, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);

    // Writes attempted under reset must not reach the array.
    do_cycle("rst_wr", 1'b0, 1'b1, 1'b1, 12'h005, 4'hF, 4'hF, 1'b1, 1'b0, 12'h005, 4'h0, 4'h0);
    check_eq("rst_q0", Q0, 4'h0);
    do_cycle("rst_wr", 1'b0, 1'b1, 1'b1, 12'h005, 4'hF, 4'hF, 1'b1, 1'b0, 12'h005, 4'h0, 4'h0);
    check_eq("rst_q1", Q1, 4'h0);
    do_cycle("rst_rd", 1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b1, 1'b0, 12'h005, 4'h0, 4'h0);
    check_eq("rst_keep", Q1, 4'hA);

    do_cycle("basic_wr", 1'b1, 1'b1, 1'b1, 12'hABC, 4'h9, 4'hF, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("basic_rd", 1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b1, 1'b0, 12'hABC, 4'h0, 4'h0);
    check_eq("basic_val", Q1, 4'h9);
    do_cycle("basic_hold", 1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b0, 1'b1, 12'h777, 4'h3, 4'hF);
    check_eq("basic_hold_val", Q1, 4'h9);

    do_cycle("mask_clr", 1'b1, 1'b1, 1'b1, 12'h123, 4'h0, 4'hF, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("mask_wr0", 1'b1, 1'b1, 1'b1, 12'h123, 4'hF, 4'h5, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("mask_rd0", 1'b1, 1'b1, 1'b0, 12'h123, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    check_eq("mask_val0", Q0, 4'h5);
    do_cycle("mask_wr1", 1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b1, 1'b1, 12'h123, 4'hF, 4'hA);
    do_cycle("mask_rd1", 1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b1, 1'b0, 12'h123, 4'h0, 4'h0);
    check_eq("mask_val1", Q1, 4'hF);
    do_cycle("mask_none", 1'b1, 1'b1, 1'b1, 12'h123, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("mask_none_rd", 1'b1, 1'b1, 1'b0, 12'h123, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    check_eq("mask_none_val", Q0, 4'hF);

    do_cycle("rf_init", 1'b1, 1'b1, 1'b1, 12'h010, 4'h3, 4'hF, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("rf_wr",   1'b1, 1'b1, 1'b1, 12'h010, 4'hC, 4'hF, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    check_eq("rf_old", Q0, 4'h3);
    do_cycle("rf_rd",   1'b1, 1'b1, 1'b0, 12'h010, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    check_eq("rf_new", Q0, 4'hC);

    do_cycle("rw_init", 1'b1, 1'b1, 1'b1, 12'h200, 4'h1, 4'hF, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    do_cycle("rw_coll", 1'b1, 1'b1, 1'b1, 12'h200, 4'h6, 4'hF, 1'b1, 1'b0, 12'h200, 4'h0, 4'h0);
    check_eq("rw_old", Q1, 4'h1);
    do_cycle("rw_rd",   1'b1, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0, 1'b1, 1'b0, 12'h200, 4'h0, 4'h0);
    check_eq("rw_new", Q1, 4'h6);

    do_cycle("ww_coll", 1'b1, 1'b1, 1'b1, 12'h300, 4'h0, 4'hF, 1'b1, 1'b1, 12'h300, 4'hF, 4'h3);
    do_cycle("ww_rd",   1'b1, 1'b1, 1'b0, 12'h300, 4'h0, 4'h0, 1'b0, 1'b0, 12'h000, 4'h0, 4'h0);
    check_eq("ww_val", Q0, 4'h3);

    do_cycle("ext_wr", 1'b1, 1'b1, 1'b1, 12'h000, 4'h7, 4'hF, 1'b1, 1'b1, 12'hFFF, 4'hE, 4'hF);
    do_cycle("ext_rd", 1'b1, 1'b1, 1'b0, 12'hFFF, 4'h0, 4'h0, 1'b1, 1'b0, 12'h000, 4'h0, 4'h0);
    check_eq("ext_q0", Q0, 4'hE);
    check_eq("ext_q1", Q1, 4'h7);

    // Random traffic: a small hot address pool forces frequent same-address collisions.
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(63) != 0);
      r_ce0 = ($urandom_range(3) != 0);
      r_we0 = $urandom_range(1);
      r_ce1 = ($urandom_range(3) != 0);
      r_we1 = $urandom_range(1);
      r_a0  = ($urandom_range(1) != 0) ? 12'($urandom_range(7)) : 12'($urandom_range(4095));
      r_a1  = ($urandom_range(1) != 0) ? 12'($urandom_range(7)) : 12'($urandom_range(4095));
      do_cycle("rand", r_rst,
               r_ce0, r_we0, r_a0, 4'($urandom_range(15)), 4'($urandom_range(15)),
               r_ce1, r_we1, r_a1, 4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_4096x4_dp.md
Name: bram_4096x4_dp

Overview:
- True dual-port synchronous RAM, 4096 words x 4 bits.
- Each port independently reads or writes, with a per-bit write mask.
- Leaf bank of the ESP unisim SRAM wrappers. The wrappers tile these banks horizontally (nibble slices) and steer CE/A/D/WE/WEM per bank.
- Both ports run on one shared clock.

Parameters:
- ADDR_WIDTH, 12, address bits per port; depth = 2**ADDR_WIDTH = 4096.
- DATA_WIDTH, 4, word width; also the width of the write mask.

Ports:
- CLK  input  1  single clock for both ports, rising-edge active.
- RSTN  input  1  synchronous active-low reset.
- CE0  input  1  port 0 enable.
- A0  input  ADDR_WIDTH  port 0 address.
- D0  input  DATA_WIDTH  port 0 write data.
- WE0  input  1  port 0 write enable (1 = write, 0 = read).
- WEM0  input  DATA_WIDTH  port 0 per-bit write mask (1 = bit written).
- Q0  output  DATA_WIDTH  port 0 registered read data.
- CE1  input  1  port 1 enable.
- A1  input  ADDR_WIDTH  port 1 address.
- D1  input  DATA_WIDTH  port 1 write data.
- WE1  input  1  port 1 write enable.
- WEM1  input  DATA_WIDTH  port 1 per-bit write mask.
- Q1  output  DATA_WIDTH  port 1 registered read data.

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-low (RSTN). All state changes happen on the rising edge of CLK.
- Reset:
  - At a rising edge with RSTN=0: Q0 and Q1 go to 0.
  - All reads and writes are ignored during reset.
  - Memory array contents are not cleared by reset. Power-up contents are undefined (X in simulation).
- Port idle: with CEp=0, no access occurs, Qp holds its previous value, and WEp/WEMp/Dp are don't-care.
- Read (CEp=1, WEp=0): Qp <= mem[Ap] at the edge. Latency is 1 cycle, and Qp holds until the next access or reset.
- Write (CEp=1, WEp=1):
  - For each bit i with WEMp[i]=1: mem[Ap][i] <= Dp[i].
  - Bits with WEMp[i]=0 are unchanged. WEMp=0 writes nothing.
- Read-first on the writing port: a write also updates Qp with the OLD word at Ap (pre-write contents).
- Same address on both ports, same edge:
  - Read vs write: the reading port returns the old data; the write completes normally.
  - Write vs write: bits enabled on both masks take port 1's data; bits enabled on one mask only take that port's data.
- Different addresses: the ports are fully independent, with no mutual stalls.
- Addresses are always in range (12 bits cover all 4096 words); no wrap logic is needed.
- Outputs never drive X after reset unless an unwritten location is read.

Test Plan:
- Reset: RSTN=0 for 2 edges with CE0=CE1=1, WE0=1, A0=0x005, D0=0xF, WEM0=0xF; then RSTN=1 and read 0x005 on port 1 -> Q0=Q1=0 during reset; the location is not written (reads X / previous value).
- Basic write/read: port 0 writes A0=0xABC, D0=0x9, WEM0=0xF; next cycle port 1 reads A1=0xABC -> Q1=0x9 exactly one cycle after the read edge; Q1 then holds 0x9 with CE1=0.
- Masked write: write 0x0 to 0x123 with WEM=0xF; then write D=0xF with WEM=0x5; read 0x123 -> 0x5. Repeat via port 1 with WEM1=0xA -> 0xF.
- Read-first: mem[0x010]=0x3; port 0 writes 0xC to 0x010 -> Q0=0x3 after that edge; subsequent read -> 0xC.
- Cross-port collision:
  - mem[0x200]=0x1; port 0 writes 0x6 while port 1 reads 0x200 -> Q1=0x1; the next read returns 0x6.
  - Both ports write 0x300: D0=0x0, WEM0=0xF; D1=0xF, WEM1=0x3 -> mem=0x3.
- Extremes and independence: simultaneous writes to 0x000 (port 0, 0x7) and 0xFFF (port 1, 0xE), then cross-read (port 0 reads 0xFFF, port 1 reads 0x000) -> Q0=0xE, Q1=0x7.
